// File: rtl/bip_data_mem.sv
// rtl/bip_data_mem.sv - CPU data memory with a background dump port that yields to CPU accesses.
// Optional macro BIP_MEM_ACCESS_CNT_EN adds saturating CPU read/write access counters.
module bip_data_mem #(
  parameter int NB_ADDR = 11,
  parameter int NB_DATA = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_WrRam,
  input  logic               i_RdRam,
  output logic [NB_DATA-1:0] o_data,
  input  logic               i_dump_start,
  input  logic [NB_ADDR-1:0] i_dump_last,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_busy,
  output logic               o_dump_done,
  output logic [15:0]        o_cnt_rd,
  output logic [15:0]        o_cnt_wr
);

  localparam int DEPTH = 2 ** NB_ADDR;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  logic [NB_DATA-1:0] mem [0:DEPTH-1];

  state_t             state;
  state_t             state_next;
  logic [NB_ADDR-1:0] ptr;
  logic [NB_ADDR-1:0] last;
  logic [NB_ADDR-1:0] dump_addr;
  logic [NB_DATA-1:0] dump_data;
  logic               done;
  logic               start_en;
  logic               fetch_en;
  logic               advance;
  logic               finish;
  logic               cpu_busy;

  assign cpu_busy = i_RdRam | i_WrRam;

  // Storage array is never reset; contents survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (i_WrRam) begin
      mem[i_addr] <= i_data;
    end
  end

  // Write-first on a simultaneous read/write; o_data holds when no read.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_data <= '0;
    end else if (i_RdRam) begin
      o_data <= i_WrRam ? i_data : mem[i_addr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_en   = 1'b0;
    fetch_en   = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (i_dump_start) begin
          start_en   = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        // The dump only borrows the port on cycles the CPU leaves idle.
        if (!cpu_busy) begin
          fetch_en   = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (i_dump_ready) begin
          if (ptr == last) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ptr       <= '0;
      last      <= '0;
      dump_addr <= '0;
      dump_data <= '0;
      done      <= 1'b0;
    end else begin
      if (start_en) begin
        last <= i_dump_last;
        ptr  <= '0;
      end
      if (fetch_en) begin
        dump_addr <= ptr;
        dump_data <= mem[ptr];
      end
      if (advance) begin
        ptr <= ptr + 1'b1;
      end
      done <= finish;
    end
  end

  assign o_dump_valid = (state == SEND);
  assign o_dump_busy  = (state != IDLE);
  assign o_dump_addr  = dump_addr;
  assign o_dump_data  = dump_data;
  assign o_dump_done  = done;

`ifdef BIP_MEM_ACCESS_CNT_EN
  logic [15:0] cnt_rd;
  logic [15:0] cnt_wr;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_rd <= '0;
      cnt_wr <= '0;
    end else begin
      if (i_RdRam && (cnt_rd != 16'hFFFF)) begin
        cnt_rd <= cnt_rd + 16'd1;
      end
      if (i_WrRam && (cnt_wr != 16'hFFFF)) begin
        cnt_wr <= cnt_wr + 16'd1;
      end
    end
  end

  assign o_cnt_rd = cnt_rd;
  assign o_cnt_wr = cnt_wr;
`else
  assign o_cnt_rd = 16'd0;
  assign o_cnt_wr = 16'd0;
`endif

endmodule
